// File: rtl/count_sequencer.sv
// ============================================================================
// count_sequencer: timed up/down counter stepping load_val toward limit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module count_sequencer #(
  parameter int WIDTH = 4,
  parameter int DIV   = 25000000,
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             step,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] presc, presc_n;
  logic             dir_q, dir_n;
  logic [WIDTH-1:0] limit_q, limit_n;
  logic [WIDTH-1:0] value_n;
  logic             busy_n, step_n, done_n;
  logic             tick;

  assign tick = (presc == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      presc   <= '0;
      dir_q   <= 1'b0;
      limit_q <= '0;
      value   <= '0;
      busy    <= 1'b0;
      step    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      dir_q   <= dir_n;
      limit_q <= limit_n;
      value   <= value_n;
      busy    <= busy_n;
      step    <= step_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    presc_n = presc;
    dir_n   = dir_q;
    limit_n = limit_q;
    value_n = value;
    busy_n  = busy;
    step_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          value_n = load_val;
          dir_n   = dir;
          limit_n = limit;
          presc_n = '0;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          presc_n = '0;
          if (value == limit_q) begin
            state_n = DONE;
          end else begin
            value_n = dir_q ? (value - 1'b1) : (value + 1'b1);
            step_n  = 1'b1;
          end
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      // busy stays up through the DONE cycle and drops together with done.
      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_count_sequencer.sv
// ============================================================================
// tb_count_sequencer: self-checking bench for count_sequencer (DIV = 4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_count_sequencer;

  localparam int WIDTH = 4;
  localparam int DIV   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             dir = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] limit = '0;
  logic [WIDTH-1:0] value;
  logic             busy, step, done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  count_sequencer #(.WIDTH(WIDTH), .DIV(DIV), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir),
    .load_val(load_val), .limit(limit),
    .value(value), .busy(busy), .step(step), .done(done)
  );

  always #5 clk = ~clk;

  // Expected {value, busy, step, done} k edges after the start edge.
  function automatic logic [6:0] model(int k, logic [3:0] ld, logic [3:0] lim, logic d);
    int n, s;
    logic [3:0] v;
    n = d ? ((int'(ld) - int'(lim)) & 15) : ((int'(lim) - int'(ld)) & 15);
    s = k / DIV;
    if (s > n) s = n;
    v = d ? 4'(int'(ld) - s) : 4'(int'(ld) + s);
    return {v, (k <= (n + 1) * DIV), (k > 0 && k % DIV == 0 && k / DIV <= n),
            (k == (n + 1) * DIV + 1)};
  endfunction

  function automatic int seq_len(logic [3:0] ld, logic [3:0] lim, logic d);
    int n;
    n = d ? ((int'(ld) - int'(lim)) & 15) : ((int'(lim) - int'(ld)) & 15);
    return (n + 1) * DIV + 1;
  endfunction

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [3:0] ld, logic [3:0] lim, logic d);
    load_val = ld; limit = lim; dir = d; start = 1'b1;
    tick_edge();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick_edge();
    tick_edge();
    reset = 1'b0;
    total_cnt++;
    if ({value, busy, step, done} !== 7'd0)
      $display("FAIL reset: got %b want %b", {value, busy, step, done}, 7'd0);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      tick_edge();
      total_cnt++;
      if ({value, busy, step, done} !== 7'd0)
        $display("FAIL reset_idle c%0d: got %b want %b", i, {value, busy, step, done}, 7'd0);
      else pass_cnt++;
    end
  endtask

  task automatic test_sequence(string name, logic [3:0] ld, logic [3:0] lim, logic d);
    int len;
    len = seq_len(ld, lim, d);
    do_start(ld, lim, d);
    for (int k = 0; k <= len + 3; k++) begin
      if (k > 0) tick_edge();
      total_cnt++;
      if ({value, busy, step, done} !== model(k, ld, lim, d))
        $display("FAIL %s k=%0d: got %b want %b", name, k, {value, busy, step, done},
                 model(k, ld, lim, d));
      else pass_cnt++;
    end
  endtask

  task automatic test_ignored_inputs();
    do_start(4'd2, 4'd5, 1'b0);
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick_edge();
      start = 1'b0;
      total_cnt++;
      if ({value, busy, step, done} !== model(k, 4'd2, 4'd5, 1'b0))
        $display("FAIL ignored k=%0d: got %b want %b", k, {value, busy, step, done},
                 model(k, 4'd2, 4'd5, 1'b0));
      else pass_cnt++;
      if (k == 5) begin dir = 1'b1; limit = 4'd0; load_val = 4'd12; start = 1'b1; end
      if (k == 9) dir = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run();
    do_start(4'd2, 4'd5, 1'b0);
    for (int k = 1; k <= 5; k++) tick_edge();
    total_cnt++;
    if (value !== 4'd3) $display("FAIL midrun_pre: got %0d want %0d", value, 3);
    else pass_cnt++;
    reset = 1'b1;
    tick_edge();
    reset = 1'b0;
    total_cnt++;
    if ({value, busy, step, done} !== 7'd0)
      $display("FAIL midrun_abort: got %b want %b", {value, busy, step, done}, 7'd0);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      tick_edge();
      total_cnt++;
      if ({value, busy, step, done} !== 7'd0)
        $display("FAIL midrun_quiet c%0d: got %b want %b", i, {value, busy, step, done}, 7'd0);
      else pass_cnt++;
    end
    test_sequence("after_reset", 4'd7, 4'd9, 1'b0);
  endtask

  task automatic test_back_to_back();
    int len;
    len = seq_len(4'd3, 4'd4, 1'b0);
    load_val = 4'd3; limit = 4'd4; dir = 1'b0; start = 1'b1;
    tick_edge();
    for (int k = 0; k < len + 1; k++) begin
      if (k > 0) tick_edge();
      total_cnt++;
      if ({value, busy, step, done} !== model(k, 4'd3, 4'd4, 1'b0))
        $display("FAIL b2b_first k=%0d: got %b want %b", k, {value, busy, step, done},
                 model(k, 4'd3, 4'd4, 1'b0));
      else pass_cnt++;
      if (k == len) begin load_val = 4'd10; limit = 4'd10; end
    end
    tick_edge();
    start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick_edge();
      total_cnt++;
      if ({value, busy, step, done} !== model(k, 4'd10, 4'd10, 1'b0))
        $display("FAIL b2b_second k=%0d: got %b want %b", k, {value, busy, step, done},
                 model(k, 4'd10, 4'd10, 1'b0));
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [3:0] ld, lim;
    logic       d;
    int         len;
    for (int t = 0; t < 8; t++) begin
      ld  = 4'($urandom_range(0, 15));
      lim = 4'($urandom_range(0, 15));
      d   = 1'($urandom_range(0, 1));
      len = seq_len(ld, lim, d);
      do_start(ld, lim, d);
      for (int k = 0; k <= len + 2; k++) begin
        if (k > 0) tick_edge();
        total_cnt++;
        if ({value, busy, step, done} !== model(k, ld, lim, d))
          $display("FAIL random t%0d k=%0d: got %b want %b", t, k, {value, busy, step, done},
                   model(k, ld, lim, d));
        else pass_cnt++;
        if (k < len - 1) begin
          dir = 1'($urandom_range(0, 1));
          limit = 4'($urandom_range(0, 15));
          load_val = 4'($urandom_range(0, 15));
          start = 1'($urandom_range(0, 1));
        end else begin
          start = 1'b0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence("count_up", 4'd2, 4'd5, 1'b0);
    test_sequence("down_wrap", 4'd1, 4'd14, 1'b1);
    test_sequence("equal", 4'd9, 4'd9, 1'b0);
    test_sequence("full_wrap", 4'd5, 4'd4, 1'b0);
    test_ignored_inputs();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
